// File: rtl/osc_pkg.sv
// Shared types and defaults for the operand stream checker: FSM states,
// LFSR seeds and feedback mask, and the deepest supported DUT pipeline.
package osc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } osc_state_e;

  localparam logic [31:0] OSC_LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] OSC_SEED_A    = 32'h0000_0001;
  localparam logic [31:0] OSC_SEED_B    = 32'h0000_ACE1;

  localparam int OSC_MAX_DUT_LATENCY = 15;

endpackage

// File: rtl/operand_stream_checker_if.sv
// Operand/result bus between the checker (master) and the arithmetic DUT (slave).
// Operands are plain levels; the DUT answers a fixed number of cycles later.
interface operand_stream_checker_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] o_drive_a;
  logic [WIDTH-1:0] o_drive_b;
  logic [WIDTH-1:0] i_dut_out;

  modport master (
    output o_drive_a,
    output o_drive_b,
    input  i_dut_out
  );

  modport slave (
    input  o_drive_a,
    input  o_drive_b,
    output i_dut_out
  );

endinterface

// File: rtl/lfsr_gen.sv
// Galois LFSR that advances only when step is high; a zero seed is forced to 1
// so the register can never lock up in the all-zero state.
module lfsr_gen
  import osc_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(OSC_SEED_A),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(OSC_LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (step) begin
      value_d = (value_q << 1) ^ (value_q[WIDTH-1] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= SEED_EFF;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/operand_stream_checker.sv
// Drives LFSR operand pairs into the DUT and checks its sum DUT_LATENCY cycles later,
// counting compares and mismatches. Define OSC_FIRST_ERR_CAPTURE_EN to capture the first failure.
module operand_stream_checker
  import osc_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          DUT_LATENCY = 2,
  parameter int          CTR_WIDTH   = 32,
  parameter logic [31:0] SEED_A      = OSC_SEED_A,
  parameter logic [31:0] SEED_B      = OSC_SEED_B,
  parameter logic [31:0] LFSR_TAPS   = OSC_LFSR_TAPS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      freeze,
  operand_stream_checker_if.master  dut_if,
  output logic [WIDTH-1:0]          o_data_ctr,
  output logic [WIDTH-1:0]          o_event_ctr,
  output logic                      o_busy
`ifdef OSC_FIRST_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0]          o_err_a,
  output logic [WIDTH-1:0]          o_err_b,
  output logic [WIDTH-1:0]          o_err_s,
  output logic                      o_err_valid
`endif
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] exp;
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`endif
  } slot_t;

  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  osc_state_e             state_q;
  logic                   busy_q;
  logic                   gen;
  logic                   pending;
  logic [WIDTH-1:0]       lfsr_a, lfsr_b;
  logic [WIDTH-1:0]       drive_a_q, drive_a_d, drive_b_q, drive_b_d;
  logic                   launch_vld_q, launch_vld_d;
  logic [CTR_WIDTH-1:0]   data_ctr_q, data_ctr_d, event_ctr_q, event_ctr_d;
  logic                   mismatch;
  slot_t                  launch_slot, cmp_slot;

  assign gen = (state_q == RUN) && enable;

  lfsr_gen #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_A)), .TAPS(WIDTH'(LFSR_TAPS))) u_lfsr_a (
    .clk(clk), .reset(reset), .step(gen), .value(lfsr_a)
  );
  lfsr_gen #(.WIDTH(WIDTH), .SEED(WIDTH'(SEED_B)), .TAPS(WIDTH'(LFSR_TAPS))) u_lfsr_b (
    .clk(clk), .reset(reset), .step(gen), .value(lfsr_b)
  );

  // launch_vld_q marks the cycle the drive registers first show a new sample,
  // so the expected sum is taken from the drive registers themselves.
  always_comb begin
    drive_a_d    = gen ? lfsr_a : drive_a_q;
    drive_b_d    = gen ? lfsr_b : drive_b_q;
    launch_vld_d = gen;
    launch_slot     = '0;
    launch_slot.vld = launch_vld_q;
    launch_slot.exp = drive_a_q + drive_b_q;
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    launch_slot.a   = drive_a_q;
    launch_slot.b   = drive_b_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drive_a_q    <= '0;
      drive_b_q    <= '0;
      launch_vld_q <= 1'b0;
    end else begin
      drive_a_q    <= drive_a_d;
      drive_b_q    <= drive_b_d;
      launch_vld_q <= launch_vld_d;
    end
  end

  // pending excludes the output stage: that sample is being compared this cycle.
  if (DUT_LATENCY == 0) begin : g_no_delay
    assign cmp_slot = launch_slot;
    assign pending  = 1'b0;
  end else begin : g_delay
    slot_t line_q [DUT_LATENCY];
    slot_t line_d [DUT_LATENCY];

    always_comb begin
      line_d[0] = launch_slot;
      for (int i = 1; i < DUT_LATENCY; i++) line_d[i] = line_q[i-1];
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < DUT_LATENCY; i++) begin
        line_q[i] <= reset ? '0 : line_d[i];
      end
    end

    always_comb begin
      pending = launch_vld_q;
      for (int i = 0; i < DUT_LATENCY - 1; i++) pending = pending | line_q[i].vld;
    end

    assign cmp_slot = line_q[DUT_LATENCY-1];
  end

  assign mismatch = cmp_slot.vld && (cmp_slot.exp != dut_if.i_dut_out);

  always_comb begin
    data_ctr_d  = data_ctr_q;
    event_ctr_d = event_ctr_q;
    if (cmp_slot.vld && !freeze) begin
      if (data_ctr_q != CTR_MAX) data_ctr_d = data_ctr_q + CTR_WIDTH'(1);
      if (mismatch && event_ctr_q != CTR_MAX) event_ctr_d = event_ctr_q + CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ctr_q  <= '0;
      event_ctr_q <= '0;
    end else begin
      data_ctr_q  <= data_ctr_d;
      event_ctr_q <= event_ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (!enable) state_q <= DRAIN;
        DRAIN: begin
          if (enable) begin
            state_q <= RUN;
          end else if (!pending) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OSC_FIRST_ERR_CAPTURE_EN
  logic             err_vld_q, err_vld_d;
  logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d, err_s_q, err_s_d;

  always_comb begin
    err_vld_d = err_vld_q;
    err_a_d   = err_a_q;
    err_b_d   = err_b_q;
    err_s_d   = err_s_q;
    if (mismatch && !err_vld_q) begin
      err_vld_d = 1'b1;
      err_a_d   = cmp_slot.a;
      err_b_d   = cmp_slot.b;
      err_s_d   = dut_if.i_dut_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_vld_q <= 1'b0;
      err_a_q   <= '0;
      err_b_q   <= '0;
      err_s_q   <= '0;
    end else begin
      err_vld_q <= err_vld_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
      err_s_q   <= err_s_d;
    end
  end

  assign o_err_valid = err_vld_q;
  assign o_err_a     = err_a_q;
  assign o_err_b     = err_b_q;
  assign o_err_s     = err_s_q;
`endif

  assign dut_if.o_drive_a = drive_a_q;
  assign dut_if.o_drive_b = drive_b_q;
  assign o_data_ctr       = WIDTH'(data_ctr_q);
  assign o_event_ctr      = WIDTH'(event_ctr_q);
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_operand_stream_checker.sv
// Directed bench: a latency-2 checker against a registered adder with error injection,
// a 4-bit-counter checker against an always-wrong DUT, and a latency-0 checker for reset mid-run.
module tb_operand_stream_checker;

  logic clk = 1'b0;
  logic rst;
  logic en_m, en_s, en_z, frz;
  logic [31:0] m_data, m_event, s_data, s_event, z_data, z_event;
  logic        m_busy, s_busy, z_busy;
  int          n_chk = 0;
  int          n_pass = 0;
  int          bad0 = 1000, bad1 = 1000, bad2 = 1000;

`ifdef OSC_FIRST_ERR_CAPTURE_EN
  logic [31:0] m_err_a, m_err_b, m_err_s, s_err_a, s_err_b, s_err_s, z_err_a, z_err_b, z_err_s;
  logic        m_err_v, s_err_v, z_err_v;
`endif

  always #5 clk = ~clk;

  operand_stream_checker_if #(.WIDTH(32)) m_if ();
  operand_stream_checker_if #(.WIDTH(32)) s_if ();
  operand_stream_checker_if #(.WIDTH(32)) z_if ();

  operand_stream_checker #(.WIDTH(32), .DUT_LATENCY(2), .CTR_WIDTH(32)) u_main (
    .clk(clk), .reset(rst), .enable(en_m), .freeze(frz), .dut_if(m_if),
    .o_data_ctr(m_data), .o_event_ctr(m_event), .o_busy(m_busy)
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    , .o_err_a(m_err_a), .o_err_b(m_err_b), .o_err_s(m_err_s), .o_err_valid(m_err_v)
`endif
  );

  operand_stream_checker #(.WIDTH(32), .DUT_LATENCY(0), .CTR_WIDTH(4)) u_sat (
    .clk(clk), .reset(rst), .enable(en_s), .freeze(1'b0), .dut_if(s_if),
    .o_data_ctr(s_data), .o_event_ctr(s_event), .o_busy(s_busy)
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    , .o_err_a(s_err_a), .o_err_b(s_err_b), .o_err_s(s_err_s), .o_err_valid(s_err_v)
`endif
  );

  operand_stream_checker #(.WIDTH(32), .DUT_LATENCY(0), .CTR_WIDTH(32)) u_zero (
    .clk(clk), .reset(rst), .enable(en_z), .freeze(1'b0), .dut_if(z_if),
    .o_data_ctr(z_data), .o_event_ctr(z_event), .o_busy(z_busy)
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    , .o_err_a(z_err_a), .o_err_b(z_err_b), .o_err_s(z_err_s), .o_err_valid(z_err_v)
`endif
  );

  // Two-stage registered adder; bit 0 is flipped for the listed sample numbers.
  logic [31:0] m_s1, m_s2, m_prev_a;
  int          m_cnt = 0;
  int          m_cur;
  logic        m_corrupt;

  always_comb begin
    m_cur     = (m_if.o_drive_a != m_prev_a) ? m_cnt + 1 : m_cnt;
    m_corrupt = (m_cur == bad0) || (m_cur == bad1) || (m_cur == bad2);
  end

  always_ff @(posedge clk) begin
    if (rst) m_cnt <= 0;
    else if (m_if.o_drive_a != m_prev_a) m_cnt <= m_cnt + 1;
    m_prev_a <= m_if.o_drive_a;
    m_s1     <= (m_if.o_drive_a + m_if.o_drive_b) ^ {31'b0, m_corrupt};
    m_s2     <= m_s1;
  end

  assign m_if.i_dut_out = m_s2;
  assign s_if.i_dut_out = ~(s_if.o_drive_a + s_if.o_drive_b);
  assign z_if.i_dut_out = z_if.o_drive_a + z_if.o_drive_b;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en_m = 1'b0; en_s = 1'b0; en_z = 1'b0; frz = 1'b0;
    do_reset;

    check("rst_drive_a", m_if.o_drive_a, 32'h0);
    check("rst_drive_b", m_if.o_drive_b, 32'h0);
    check("rst_data",    m_data, 32'h0);
    check("rst_event",   m_event, 32'h0);
    check("rst_busy",    32'(m_busy), 32'h0);
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    check("rst_err_valid", 32'(m_err_v), 32'h0);
`endif

    // Clean run: 100 generates; samples k are seed << (k-1) until the MSB is hit.
    en_m = 1'b1;
    tick;
    check("run_busy", 32'(m_busy), 32'h1);
    tick;
    check("gen1_a", m_if.o_drive_a, 32'h1);
    check("gen1_b", m_if.o_drive_b, 32'h0000_ACE1);
    tick;
    check("gen2_a", m_if.o_drive_a, 32'h2);
    check("gen2_b", m_if.o_drive_b, 32'h0001_59C2);
    repeat (98) tick;
    en_m = 1'b0;
    tick;
    tick;
    check("drain_busy", 32'(m_busy), 32'h1);
    tick;
    check("idle_busy",   32'(m_busy), 32'h0);
    check("clean_data",  m_data, 32'd100);
    check("clean_event", m_event, 32'd0);

    // Error injection on samples 10, 11 and 50.
    do_reset;
    bad0 = 10; bad1 = 11; bad2 = 50;
    en_m = 1'b1;
    repeat (101) tick;
    en_m = 1'b0;
    repeat (3) tick;
    check("inj_event", m_event, 32'd3);
    check("inj_data",  m_data, 32'd100);
`ifdef OSC_FIRST_ERR_CAPTURE_EN
    check("cap_valid", 32'(m_err_v), 32'h1);
    check("cap_a",     m_err_a, 32'h0000_0200);
    check("cap_b",     m_err_b, 32'h0159_C200);
    check("cap_s",     m_err_s, 32'h0159_C401);
`endif
    bad0 = 1000; bad1 = 1000; bad2 = 1000;

    // Freeze over 20 of 100 generate cycles.
    do_reset;
    en_m = 1'b1;
    tick;
    repeat (30) tick;
    frz = 1'b1;
    check("frz_entry", m_data, 32'd27);
    repeat (20) tick;
    check("frz_hold",  m_data, 32'd27);
    frz = 1'b0;
    repeat (50) tick;
    en_m = 1'b0;
    repeat (3) tick;
    check("frz_data",  m_data, 32'd80);
    check("frz_event", m_event, 32'd0);

    // Saturation with 4-bit counters, every sample mismatching.
    en_s = 1'b1;
    tick;
    repeat (16) tick;
    check("sat_reach", s_data, 32'd15);
    repeat (4) tick;
    en_s = 1'b0;
    tick;
    check("sat_drain_busy", 32'(s_busy), 32'h1);
    tick;
    check("sat_idle_busy", 32'(s_busy), 32'h0);
    check("sat_data",  s_data, 32'd15);
    check("sat_event", s_event, 32'd15);

    // Reset mid-run at sample 40 on the latency-0 checker, then re-run 10 samples.
    en_z = 1'b1;
    tick;
    repeat (40) tick;
    check("z_pre_rst", z_data, 32'd39);
    rst = 1'b1;
    en_z = 1'b0;
    tick;
    check("z_rst_data",  z_data, 32'd0);
    check("z_rst_event", z_event, 32'd0);
    check("z_rst_busy",  32'(z_busy), 32'h0);
    check("z_rst_drive", z_if.o_drive_a, 32'h0);
    rst = 1'b0;
    en_z = 1'b1;
    tick;
    repeat (10) tick;
    en_z = 1'b0;
    repeat (2) tick;
    check("z_rerun_data",  z_data, 32'd10);
    check("z_rerun_event", z_event, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
